seq_detector_param: RTL and testbench

Parametrised serial pattern detector: the next generation of the fixed 4-bit sequence detector. Any PAT_W-bit pattern, run-time overlapping/non-overlapping mode, an input-qualify strobe and a saturating match counter. It sits on a 1-bit serial stream inside the datapath and flags each complete occurrence of the pattern to downstream control.

---
 rtl/seq_det_pkg.sv | 67 ++++++
 rtl/sat_counter.sv | 36 +++
 rtl/seq_detector_param.sv | 96 +++++++++
 tb/tb_seq_detector_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detector: KMP failure/transition functions
// evaluated at elaboration, plus the state-width helper and the restart-mode type.
package seq_det_pkg;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Bit j of the pattern sequence (j = 0 is the first bit received).
    function automatic logic pat_bit(input logic [31:0] pattern, input int width, input int j);
        return pattern[5'(width - 1 - j)];
    endfunction

    // Longest proper prefix of the first k pattern bits that is also a suffix of them.
    function automatic int fail_of(input logic [31:0] pattern, input int width, input int k);
        int  res;
        bit  found;
        bit  same;
        res   = 0;
        found = 1'b0;
        for (int l = k - 1; l > 0; l--) begin
            if (!found) begin
                same = 1'b1;
                for (int i = 0; i < l; i++) begin
                    if (pat_bit(pattern, width, i) != pat_bit(pattern, width, k - l + i))
                        same = 1'b0;
                end
                if (same) begin
                    res   = l;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // KMP transition; returns width when the bit completes the pattern.
    function automatic int next_state(input logic [31:0] pattern, input int width,
                                      input int s, input logic b);
        int k;
        int res;
        bit done;
        k    = s;
        res  = 0;
        done = 1'b0;
        for (int it = 0; it <= width; it++) begin
            if (!done) begin
                if (k < width && pat_bit(pattern, width, k) == b) begin
                    res  = k + 1;
                    done = 1'b1;
                end else if (k == 0) begin
                    res  = 0;
                    done = 1'b1;
                end else begin
                    k = fail_of(pattern, width, k);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: q updates on the edge that samples inc/clr. No backpressure.
// Built only when SEQ_DET_PARAM_COUNT_EN is defined.
`ifdef SEQ_DET_PARAM_COUNT_EN
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule
`endif

// File: rtl/seq_detector_param.sv
// Parametrised KMP serial pattern detector with overlap/non-overlap restart and match count.
// Latency: z/count update on the edge sampling the completing bit. No backpressure; en qualifies x.
// SEQ_DET_PARAM_COUNT_EN builds the match counter; otherwise count is 0 and clr is ignored.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       x,
    input  logic                       overlap,
    input  logic                       clr,
    output logic                       z,
    output logic [CNT_W-1:0]           count,
    output logic [$clog2(PAT_W+1)-1:0] state
);

    localparam int SW   = state_w(PAT_W);
    localparam int ROWS = 2 ** SW;
    localparam logic [SW-1:0] FULL      = SW'(PAT_W);
    localparam logic [SW-1:0] FAIL_FULL = SW'(fail_of(32'(PATTERN), PAT_W, PAT_W));

    // Transition table per input bit; rows past PAT_W-1 are unreachable.
    logic [SW-1:0] nxt0 [ROWS];
    logic [SW-1:0] nxt1 [ROWS];

    for (genvar g = 0; g < ROWS; g++) begin : g_tbl
        if (g < PAT_W) begin : g_live
            localparam logic [SW-1:0] N0 = SW'(next_state(32'(PATTERN), PAT_W, g, 1'b0));
            localparam logic [SW-1:0] N1 = SW'(next_state(32'(PATTERN), PAT_W, g, 1'b1));
            assign nxt0[g] = N0;
            assign nxt1[g] = N1;
        end else begin : g_dead
            assign nxt0[g] = '0;
            assign nxt1[g] = '0;
        end
    end

    logic [SW-1:0] state_q, state_d;
    logic          z_q, z_d;
    logic [SW-1:0] t_sel;
    logic          hit;
    mode_e         mode;

    assign mode = mode_e'(overlap);

    always_comb begin
        state_d = state_q;
        z_d     = 1'b0;
        hit     = 1'b0;
        t_sel   = x ? nxt1[state_q] : nxt0[state_q];
        if (en) begin
            if (t_sel == FULL) begin
                hit     = 1'b1;
                z_d     = 1'b1;
                state_d = (mode == MODE_OVL) ? FAIL_FULL : '0;
            end else begin
                state_d = t_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    assign z     = z_q;
    assign state = state_q;

`ifdef SEQ_DET_PARAM_COUNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (hit),
        .q   (count)
    );
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign count      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench: three detector configurations on a shared stream, checked every cycle against a
// history-based occurrence model, plus directed scenarios with literal expectations.
module tb_seq_detector_param;

`ifdef SEQ_DET_PARAM_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    localparam int          NI = 3;
    localparam int          PW [NI] = '{4, 4, 5};
    localparam logic [31:0] PT [NI] = '{32'hB, 32'hB, 32'h15};
    localparam int          CW [NI] = '{8, 2, 3};

    logic clk = 1'b0;
    logic rst, en, x, ov, clr;
    logic       z0, z1, z2;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [2:0] cnt2;
    logic [2:0] st0, st1, st2;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(ov), .clr(clr),
        .z(z0), .count(cnt0), .state(st0));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(ov), .clr(clr),
        .z(z1), .count(cnt1), .state(st1));
    seq_detector_param #(.PAT_W(5), .PATTERN(5'b10101), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(ov), .clr(clr),
        .z(z2), .count(cnt2), .state(st2));

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Model: bits accepted since the last restart; a match is the pattern ending the history.
    logic [63:0] hist [NI];
    int          hlen [NI];
    int          cnt  [NI];
    int          zexp [NI];
    int          sexp [NI];

    function automatic logic [63:0] lowmask(input int k);
        return (64'd1 << k) - 64'd1;
    endfunction

    function automatic int prefix_len(input int i);
        int r;
        r = 0;
        for (int k = PW[i] - 1; k > 0; k--) begin
            if (r == 0 && k <= hlen[i] &&
                (hist[i] & lowmask(k)) == 64'(PT[i] >> (PW[i] - k)))
                r = k;
        end
        return r;
    endfunction

    function automatic int exp_cnt(input int n, input int w);
        int top;
        top = (1 << w) - 1;
        if (!CNT_ON) return 0;
        return (n > top) ? top : n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            hist[i] = '0; hlen[i] = 0; cnt[i] = 0; zexp[i] = 0; sexp[i] = 0;
        end
    endtask

    task automatic model_step(input logic e, input logic b, input logic o, input logic c);
        for (int i = 0; i < NI; i++) begin
            zexp[i] = 0;
            if (e) begin
                hist[i] = {hist[i][62:0], b};
                if (hlen[i] < 64) hlen[i]++;
                if (hlen[i] >= PW[i] && (hist[i] & lowmask(PW[i])) == 64'(PT[i])) begin
                    zexp[i] = 1;
                    if (CNT_ON && cnt[i] < (1 << CW[i]) - 1) cnt[i]++;
                    if (!o) begin
                        hist[i] = '0;
                        hlen[i] = 0;
                    end
                end
            end
            if (c) cnt[i] = 0;
            sexp[i] = prefix_len(i);
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("u0.z", int'(z0), zexp[0]);
            check("u0.count", int'(cnt0), cnt[0]);
            check("u0.state", int'(st0), sexp[0]);
            check("u1.z", int'(z1), zexp[1]);
            check("u1.count", int'(cnt1), cnt[1]);
            check("u1.state", int'(st1), sexp[1]);
            check("u2.z", int'(z2), zexp[2]);
            check("u2.count", int'(cnt2), cnt[2]);
            check("u2.state", int'(st2), sexp[2]);
        end
    end

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cyc(input logic e, input logic b, input logic c);
        en = e; x = b; clr = c;
        @(posedge clk);
        model_step(e, b, ov, c);
        @(negedge clk);
    endtask

    task automatic do_rst(input int n);
        #2;
        rst = 1'b1;
        model_reset();
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], 1'b0);
    endtask

    logic [6:0] stream7;

    initial begin
        rst = 1'b1; en = 1'b0; x = 1'b0; ov = 1'b1; clr = 1'b0;
        model_reset();
        stream7 = 7'b1011011;
        @(negedge clk);
        chk_on = 1'b1;
        check("reset z", int'(z0), 0);
        check("reset count", int'(cnt0), 0);
        check("reset state", int'(st0), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        send_bits(16'b1011, 4);
        check("first match z", int'(z0), 1);
        check("first match count", int'(cnt0), exp_cnt(1, 8));
        cyc(1'b0, 1'b0, 1'b0);
        check("pulse one cycle", int'(z0), 0);

        do_rst(1);
        ov = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            cyc(1'b1, stream7[i], 1'b0);
            if (i == 3) check("ovl z bit4", int'(z0), 1);
            if (i == 2) check("ovl no z bit5", int'(z0), 0);
        end
        check("ovl z bit7", int'(z0), 1);
        check("ovl count", int'(cnt0), exp_cnt(2, 8));

        do_rst(1);
        ov = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            cyc(1'b1, stream7[i], 1'b0);
            if (i == 3) check("novl z bit4", int'(z0), 1);
        end
        check("novl no z bit7", int'(z0), 0);
        check("novl count", int'(cnt0), exp_cnt(1, 8));
        check("novl state", int'(st0), 1);

        do_rst(1);
        ov = 1'b1;
        cyc(1'b1, 1'b1, 1'b0); check("gap s after 1", int'(st0), 1);
        cyc(1'b0, 1'b0, 1'b0); check("gap1 frozen", int'(st0), 1);
        cyc(1'b1, 1'b0, 1'b0); check("gap s after 10", int'(st0), 2);
        cyc(1'b0, 1'b1, 1'b0); check("gap2 frozen", int'(st0), 2);
        check("gap2 no z", int'(z0), 0);
        cyc(1'b1, 1'b1, 1'b0); check("gap s after 101", int'(st0), 3);
        cyc(1'b1, 1'b1, 1'b0);
        check("gap match z", int'(z0), 1);
        check("gap restart state", int'(st0), 1);

        do_rst(1);
        ov = 1'b1;
        send_bits(16'b1011, 4);
        repeat (5) send_bits(16'b011, 3);
        check("sat count w2", int'(cnt1), exp_cnt(6, 2));
        check("count w8 six", int'(cnt0), exp_cnt(6, 8));
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        check("clr match z", int'(z1), 1);
        check("clr count w2", int'(cnt1), 0);
        check("clr count w8", int'(cnt0), 0);

        do_rst(1);
        send_bits(16'b101, 3);
        do_rst(1);
        cyc(1'b1, 1'b1, 1'b0);
        check("midrst no z", int'(z0), 0);
        check("midrst state", int'(st0), 1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) ov = ~ov;
            if ($urandom_range(0, 199) == 0)
                do_rst(1);
            else
                cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 49) == 0);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
